// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: groups, opcodes, instruction
// field positions, flag bit indices and the sequencer state encoding.
package alu_pkg;

    localparam logic GRP_ARITH = 1'b0;
    localparam logic GRP_LOGIC = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBB = 3'd3;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ROR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;

    localparam int F_GRP    = 15;
    localparam int F_OPC_HI = 14;
    localparam int F_OPC_LO = 12;
    localparam int F_RD_HI  = 11;
    localparam int F_RD_LO  = 9;
    localparam int F_RS1_HI = 8;
    localparam int F_RS1_LO = 6;
    localparam int F_RS2_HI = 5;
    localparam int F_RS2_LO = 3;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_P = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } seq_state_t;

    function automatic logic op_legal(input logic grp, input logic [2:0] opc);
        return (grp == GRP_ARITH) ? (opc <= OP_SBB) : (opc <= OP_SHL);
    endfunction

endpackage

// File: rtl/regfile8x8.sv
// Register file: one synchronous write port, three asynchronous read ports,
// synchronous clear to zero.
module regfile8x8 #(
    parameter int NREG = 8,
    parameter int W    = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] raddr3,
    output logic [W-1:0]  rdata1,
    output logic [W-1:0]  rdata2,
    output logic [W-1:0]  rdata3
);

    logic [NREG-1:0][W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign rdata3 = mem[raddr3];

endmodule

// File: rtl/alu_sequencer.sv
// Issue stage for the 8-bit ALU: decodes an instruction, registers operands
// from the register file, waits one ALU cycle, then writes result and flags back.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_instr,
    output logic         done,
    output logic         err,
    input  logic         host_we,
    input  logic [2:0]   host_addr,
    input  logic [W-1:0] host_wdata,
    output logic [W-1:0] host_rdata,
    output logic         host_ready,
    output logic [3:0]   flags_q,
    output logic         alu_grp,
    output logic [2:0]   alu_opcode,
    output logic [W-1:0] alu_op1,
    output logic [W-1:0] alu_op2,
    output logic [W-1:0] alu_op3,
    output logic [3:0]   alu_flags,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags_out
);

    seq_state_t   state, state_nx;
    logic [2:0]   rd_q;
    logic         accept, legal;
    logic         rf_we;
    logic [2:0]   rf_waddr;
    logic [W-1:0] rf_wdata, rs1_data, rs2_data;

    wire        grp_in = in_instr[F_GRP];
    wire [2:0]  opc_in = in_instr[F_OPC_HI:F_OPC_LO];
    wire [2:0]  rd_in  = in_instr[F_RD_HI:F_RD_LO];
    wire [2:0]  rs1_in = in_instr[F_RS1_HI:F_RS1_LO];
    wire [2:0]  rs2_in = in_instr[F_RS2_HI:F_RS2_LO];

    assign legal = op_legal(grp_in, opc_in);

    regfile8x8 #(.NREG(NREG), .W(W), .AW(3)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1_in),
        .raddr2 (rs2_in),
        .raddr3 (host_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .rdata3 (host_rdata)
    );

    // The host and writeback share the single write port; they never
    // overlap because the host port is closed outside IDLE.
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        host_ready = 1'b0;
        accept     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = host_addr;
        rf_wdata   = host_wdata;
        case (state)
            S_IDLE: begin
                host_ready = 1'b1;
                in_ready   = ~host_we;
                rf_we      = host_we;
                accept     = in_valid & ~host_we;
                if (accept && legal)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: state_nx = S_WB;
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = alu_result;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A reset landing in WB aborts the writeback, so the pulse is masked too.
    assign done = (state == S_WB) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            err        <= 1'b0;
            flags_q    <= '0;
            rd_q       <= '0;
            alu_grp    <= 1'b0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_op3    <= '0;
            alu_flags  <= '0;
        end else begin
            state <= state_nx;
            err   <= accept & ~legal;
            if (accept && legal) begin
                alu_grp    <= grp_in;
                alu_opcode <= opc_in;
                rd_q       <= rd_in;
                alu_op1    <= rs1_data;
                alu_op2    <= rs1_data;
                alu_op3    <= rs2_data;
                alu_flags  <= flags_q;
            end
            if (state == S_WB)
                flags_q <= alu_flags_out;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a registered ALU stand-in closes the loop, and a
// register/flags array model predicts architectural state.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        done, err;
    logic        host_we = 1'b0;
    logic [2:0]  host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_ready;
    logic [3:0]  flags_q;
    logic        alu_grp;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_op1, alu_op2, alu_op3;
    logic [3:0]  alu_flags;
    logic [7:0]  alu_result = '0;
    logic [3:0]  alu_flags_out = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mreg [8];
    logic [3:0] mflags;

    always #5 clk = ~clk;

    alu_sequencer #(.NREG(8), .W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .done(done), .err(err), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_ready(host_ready), .flags_q(flags_q), .alu_grp(alu_grp),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_op3(alu_op3), .alu_flags(alu_flags), .alu_result(alu_result),
        .alu_flags_out(alu_flags_out)
    );

    // ALU stand-in: {flags,result}. Arithmetic sets C on add carry, V on add
    // overflow or subtract borrow, Z, and P as odd parity; logic keeps flags.
    function automatic logic [11:0] alu_fn(input logic g, input logic [2:0] o,
            input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [3:0] f);
        logic [8:0] t;
        logic [7:0] r;
        logic [3:0] nf;
        nf = f;
        t  = '0;
        r  = '0;
        if (!g) begin
            case (o)
                3'd0:    t = {1'b0, a} + {1'b0, c};
                3'd1:    t = {1'b0, a} + {1'b0, c} + {8'b0, f[0]};
                3'd2:    t = {1'b0, a} - {1'b0, c};
                default: t = {1'b0, a} - {1'b0, c} - {8'b0, f[0]};
            endcase
            r     = t[7:0];
            nf[0] = (o < 3'd2) ? t[8] : 1'b0;
            nf[1] = (o < 3'd2) ? ((a[7] == c[7]) && (r[7] != a[7])) : t[8];
            nf[2] = (r == 8'h00);
            nf[3] = ^r;
        end else begin
            case (o)
                3'd0:    r = b & c;
                3'd1:    r = b | c;
                3'd2:    r = {a[0], a[7:1]};
                3'd3:    r = {a[6:0], a[7]};
                3'd4:    r = a >> 1;
                default: r = a << 1;
            endcase
        end
        return {nf, r};
    endfunction

    always @(posedge clk)
        {alu_flags_out, alu_result} <= alu_fn(alu_grp, alu_opcode, alu_op1, alu_op2, alu_op3, alu_flags);

    function automatic logic [15:0] mk(input logic g, input logic [2:0] o,
            input logic [2:0] rd, input logic [2:0] s1, input logic [2:0] s2);
        logic [2:0] rsv;
        rsv = 3'($urandom);
        return {g, o, rd, s1, s2, rsv};
    endfunction

    task automatic model_exec(input logic [15:0] ins);
        logic [11:0] o;
        logic        g;
        logic [2:0]  op;
        g  = ins[15];
        op = ins[14:12];
        if (g ? (op <= 3'd5) : (op <= 3'd3)) begin
            o = alu_fn(g, op, mreg[ins[8:6]], mreg[ins[8:6]], mreg[ins[5:3]], mflags);
            mreg[ins[11:9]] = o[7:0];
            mflags = o[11:8];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        tick();
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
        mreg[a] = d;
    endtask

    // Offers one instruction from IDLE and observes five cycles after the
    // accept edge; k counts cycles from the accept edge.
    task automatic run_instr(input logic [15:0] ins, output int dcyc, output int dcnt,
            output int ecyc, output int ecnt, output logic rdy0, output logic rdy1, output logic rdy3);
        dcyc = -1; dcnt = 0; ecyc = -1; ecnt = 0; rdy1 = 1'b0; rdy3 = 1'b0;
        tick();
        in_valid = 1'b1; in_instr = ins;
        @(negedge clk);
        rdy0 = in_ready;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
            @(negedge clk);
            if (done) begin dcnt++; if (dcyc < 0) dcyc = k; end
            if (err)  begin ecnt++; if (ecyc < 0) ecyc = k; end
            if (k == 1) rdy1 = in_ready;
            if (k == 3) rdy3 = in_ready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mflags = 4'h0;
        @(negedge clk);
        n_cmp++; if ({in_ready, host_ready, done, err} !== 4'b1100) begin n_bad++;
            $display("FAIL reset_ctl: got %b want 1100", {in_ready, host_ready, done, err}); end
        n_cmp++; if (flags_q !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", flags_q); end
        n_cmp++; if ({alu_grp, alu_opcode, alu_op1, alu_op2, alu_op3, alu_flags} !== 32'h0) begin n_bad++;
            $display("FAIL reset_alu: got %h want 0", {alu_grp, alu_opcode, alu_op1, alu_op2, alu_op3, alu_flags}); end
        for (int i = 0; i < 8; i++) begin
            host_addr = 3'(i); #1;
            n_cmp++; if (host_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_R%0d: got %h want 00", i, host_rdata); end
        end
    endtask

    task automatic test_add();
        int dc, dn, ec, en; logic r0, r1, r3;
        logic [15:0] ins;
        host_write(3'd1, 8'hF0);
        host_write(3'd2, 8'h20);
        ins = mk(1'b0, 3'd0, 3'd3, 3'd1, 3'd2);
        run_instr(ins, dc, dn, ec, en, r0, r1, r3);
        model_exec(ins);
        n_cmp++; if ({r0, r1, r3} !== 3'b101) begin n_bad++; $display("FAIL add_ready: got %b want 101", {r0, r1, r3}); end
        n_cmp++; if (dc !== 2 || dn !== 1 || en !== 0) begin n_bad++;
            $display("FAIL add_done: got cyc=%0d cnt=%0d err=%0d want 2 1 0", dc, dn, en); end
        n_cmp++; if ({alu_op1, alu_op2, alu_op3} !== 24'hF0F020) begin n_bad++;
            $display("FAIL add_ops: got %h want f0f020", {alu_op1, alu_op2, alu_op3}); end
        host_addr = 3'd3; #1;
        n_cmp++; if (host_rdata !== 8'h10) begin n_bad++; $display("FAIL add_R3: got %h want 10", host_rdata); end
        n_cmp++; if (flags_q !== 4'b1001) begin n_bad++; $display("FAIL add_flags: got %b want 1001", flags_q); end
    endtask

    task automatic test_sub();
        int dc, dn, ec, en; logic r0, r1, r3;
        logic [15:0] ins;
        host_write(3'd1, 8'h05);
        host_write(3'd2, 8'h07);
        ins = mk(1'b0, 3'd2, 3'd4, 3'd1, 3'd2);
        run_instr(ins, dc, dn, ec, en, r0, r1, r3);
        model_exec(ins);
        n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL sub_done: got %0d want 2", dc); end
        host_addr = 3'd4; #1;
        n_cmp++; if (host_rdata !== 8'hFE) begin n_bad++; $display("FAIL sub_R4: got %h want fe", host_rdata); end
        n_cmp++; if (flags_q !== 4'b1010) begin n_bad++; $display("FAIL sub_flags: got %b want 1010", flags_q); end
    endtask

    task automatic test_rol();
        int dc, dn, ec, en; logic r0, r1, r3;
        logic [15:0] ins;
        host_write(3'd5, 8'h81);
        ins = mk(1'b1, 3'd3, 3'd5, 3'd5, 3'($urandom));
        run_instr(ins, dc, dn, ec, en, r0, r1, r3);
        model_exec(ins);
        n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL rol_done: got %0d want 2", dc); end
        n_cmp++; if (alu_flags !== 4'b1010) begin n_bad++; $display("FAIL rol_flagsin: got %b want 1010", alu_flags); end
        host_addr = 3'd5; #1;
        n_cmp++; if (host_rdata !== 8'h03) begin n_bad++; $display("FAIL rol_R5: got %h want 03", host_rdata); end
        n_cmp++; if (flags_q !== 4'b1010) begin n_bad++; $display("FAIL rol_flags: got %b want 1010", flags_q); end
    endtask

    task automatic test_illegal();
        int dc, dn, ec, en; logic r0, r1, r3;
        logic [15:0] bad [2];
        bad[0] = mk(1'b0, 3'd4, 3'd1, 3'd2, 3'd3);
        bad[1] = mk(1'b1, 3'd6, 3'd0, 3'd1, 3'd1);
        for (int b = 0; b < 2; b++) begin
            run_instr(bad[b], dc, dn, ec, en, r0, r1, r3);
            n_cmp++; if (ec !== 1 || en !== 1 || dn !== 0) begin n_bad++;
                $display("FAIL illegal%0d_pulse: got err_cyc=%0d err_cnt=%0d done_cnt=%0d want 1 1 0", b, ec, en, dn); end
            n_cmp++; if (r1 !== 1'b1) begin n_bad++; $display("FAIL illegal%0d_ready: got %b want 1", b, r1); end
            n_cmp++; if (flags_q !== mflags) begin n_bad++; $display("FAIL illegal%0d_flags: got %b want %b", b, flags_q, mflags); end
            for (int i = 0; i < 8; i++) begin
                host_addr = 3'(i); #1;
                n_cmp++; if (host_rdata !== mreg[i]) begin n_bad++;
                    $display("FAIL illegal%0d_R%0d: got %h want %h", b, i, host_rdata, mreg[i]); end
            end
        end
    endtask

    task automatic test_host_arb();
        logic [15:0] ins;
        logic [7:0]  r2_old;
        ins = mk(1'b0, 3'd0, 3'd7, 3'd6, 3'd0);
        r2_old = mreg[2];
        tick();
        host_we = 1'b1; host_addr = 3'd6; host_wdata = 8'h5A;
        in_valid = 1'b1; in_instr = ins;
        @(negedge clk);
        n_cmp++; if ({in_ready, host_ready} !== 2'b01) begin n_bad++;
            $display("FAIL arb_collide: got ready/hready %b want 01", {in_ready, host_ready}); end
        tick();
        host_we = 1'b0;
        mreg[6] = 8'h5A;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arb_retry_ready: got %b want 1", in_ready); end
        host_addr = 3'd6; #1;
        n_cmp++; if (host_rdata !== 8'h5A) begin n_bad++; $display("FAIL arb_R6: got %h want 5a", host_rdata); end
        tick();
        in_valid = 1'b0;
        host_we = 1'b1; host_addr = 3'd2; host_wdata = ~r2_old;
        @(negedge clk);
        n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL arb_issue_hready: got %b want 0", host_ready); end
        n_cmp++; if (alu_op1 !== 8'h5A) begin n_bad++; $display("FAIL arb_op1: got %h want 5a", alu_op1); end
        tick();
        host_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL arb_done: got %b want 1", done); end
        tick();
        model_exec(ins);
        host_addr = 3'd2; #1;
        n_cmp++; if (host_rdata !== r2_old) begin n_bad++; $display("FAIL arb_R2_kept: got %h want %h", host_rdata, r2_old); end
        host_addr = 3'd7; #1;
        n_cmp++; if (host_rdata !== mreg[7]) begin n_bad++; $display("FAIL arb_R7: got %h want %h", host_rdata, mreg[7]); end
    endtask

    task automatic test_reset_mid();
        host_write(3'd1, 8'h33);
        tick();
        in_valid = 1'b1; in_instr = mk(1'b0, 3'd0, 3'd1, 3'd1, 3'd1);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mflags = 4'h0;
        @(negedge clk);
        n_cmp++; if ({in_ready, done, flags_q} !== 6'b100000) begin n_bad++;
            $display("FAIL rstmid_state: got rdy=%b done=%b flags=%b want 1 0 0000", in_ready, done, flags_q); end
        for (int i = 0; i < 8; i++) begin
            host_addr = 3'(i); #1;
            n_cmp++; if (host_rdata !== 8'h00) begin n_bad++; $display("FAIL rstmid_R%0d: got %h want 00", i, host_rdata); end
        end
    endtask

    task automatic test_random();
        int dc, dn, ec, en; logic r0, r1, r3;
        logic [15:0] ins;
        logic        lg;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                host_write(3'($urandom), 8'($urandom));
            end else begin
                ins = 16'($urandom);
                lg  = ins[15] ? (ins[14:12] <= 3'd5) : (ins[14:12] <= 3'd3);
                run_instr(ins, dc, dn, ec, en, r0, r1, r3);
                model_exec(ins);
                if (lg) begin
                    n_cmp++; if (dc !== 2 || dn !== 1 || en !== 0 || r3 !== 1'b1) begin n_bad++;
                        $display("FAIL rand%0d_legal %h: got dcyc=%0d dcnt=%0d ecnt=%0d rdy3=%b want 2 1 0 1", it, ins, dc, dn, en, r3); end
                end else begin
                    n_cmp++; if (ec !== 1 || en !== 1 || dn !== 0) begin n_bad++;
                        $display("FAIL rand%0d_illegal %h: got ecyc=%0d ecnt=%0d dcnt=%0d want 1 1 0", it, ins, ec, en, dn); end
                end
                n_cmp++; if (flags_q !== mflags) begin n_bad++;
                    $display("FAIL rand%0d_flags %h: got %b want %b", it, ins, flags_q, mflags); end
            end
            if (it % 10 == 9) begin
                for (int i = 0; i < 8; i++) begin
                    host_addr = 3'(i); #1;
                    n_cmp++; if (host_rdata !== mreg[i]) begin n_bad++;
                        $display("FAIL rand%0d_R%0d: got %h want %h", it, i, host_rdata, mreg[i]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_rol();
        test_illegal();
        test_host_arb();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
